led_chain_node: RTL and testbench
=================================

Name: led_chain_node

Overview:
- Parametrised successor to the single-LED serial controller.
- Decodes a WS2812-style one-wire pulse-width stream.
- Captures the first NUM_CHANNELS x BITS_PER_CH bits of each frame and forwards all later bits downstream on o_serial.
- Publishes the captured data atomically when an idle-low latch gap ends the frame. Sits at the top of the LED datapath, one instance per node in a daisy chain.

Parameters:
NUM_CHANNELS, 1, LEDs (channels) captured per node; 1..8
BITS_PER_CH, 24, bits per channel; 24 (RGB) or 32 (RGBW)
DEBOUNCE_CYCLES, 5, consecutive identical synced samples required to accept a level change
CWIDTH, 10, width of pulse/latch counters
T_THRESH, 60, high-pulse length (cycles) at or above which a bit decodes as 1
T_LATCH, 1000, consecutive low cycles that end a frame; must be < 2^CWIDTH

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_serial  in  1  asynchronous serial input
o_serial  out  1  forwarded serial stream to next node
o_led_data  out  NUM_CHANNELS*BITS_PER_CH  latched frame; channel 0 in MSBs, each channel MSB-first
o_frame_valid  out  1  one-cycle pulse when o_led_data updates
o_frame_err  out  1  one-cycle pulse when a short frame is discarded
o_frame_count  out  16  frames latched (feature-dependent)
o_err_count  out  8  short frames discarded (feature-dependent)

Behaviour:
- Single clock i_clk. i_rst_n is asynchronous assert, active-low. All outputs reset to 0. State resets to IDLE and all counters reset to 0.
- Input conditioning:
  - 2-flop synchronizer, then debounce filter, producing s_in.
  - s_in changes only after DEBOUNCE_CYCLES equal synced samples.
  - Glitches shorter than this are ignored.
- Rising and falling edges of s_in are one-cycle strobes.
- High counter: cleared on rising edge; increments while s_in high; saturates at 2^CWIDTH-1.
- Low counter: cleared while s_in high; increments while s_in low; saturates at 2^CWIDTH-1.
- Bit decode: on a falling edge, bit = (high count >= T_THRESH).
- FSM:
  - IDLE: o_serial=0. Go to CAPTURE on a rising edge.
  - CAPTURE: o_serial=0. On each falling edge, shift the decoded bit into the capture register MSB-first and increment the bit counter. When the bit counter reaches NUM_CHANNELS*BITS_PER_CH on that edge, go to FORWARD.
  - FORWARD: o_serial = s_in registered one cycle (1-cycle latency). Decoded bits do not touch the capture register.
  - In CAPTURE or FORWARD, when the low counter equals T_LATCH, take the latch action at the next clock edge, then return to IDLE:
    - Full capture (bit counter = N): o_led_data <= capture register; pulse o_frame_valid.
    - 0 < bit counter < N: o_led_data unchanged; pulse o_frame_err; discard the capture.
    - In both cases, clear the bit counter.
- The latch action fires once per gap; continued low does not repeat it.
- IDLE never pulses either strobe.
- Boundaries:
  - The final captured bit's high phase is never forwarded. Forwarding starts at the next rising edge.
  - A high held indefinitely saturates the high counter and decodes as 1 at its eventual fall.
  - A low gap of T_LATCH-1 cycles is not a latch; the frame continues.
  - Reset mid-frame discards the partial capture and clears o_led_data.
  - o_frame_valid and o_frame_err are mutually exclusive.

Optional Feature:
- Macro LED_FRAME_STATS_EN.
- Defined:
  - o_frame_count increments on every o_frame_valid and wraps at 2^16.
  - o_err_count increments on every o_frame_err and saturates at 255.
  - Both reset to 0.
- Undefined: both ports are always present and tied to 0; no counter logic is built.

Test Plan:
1. NUM_CHANNELS=1, 24 bits 0xA5C3F0 (1-bit=80-cycle high, 0-bit=30-cycle high, 50-cycle lows), then 1000 low cycles -> o_led_data=0xA5C3F0, one o_frame_valid pulse, o_serial stayed 0.
2. NUM_CHANNELS=2, BITS_PER_CH=32, send 72 bits -> o_led_data = first 64 bits; o_serial reproduces the last 8 pulses delayed by the sync+debounce latency plus 1 cycle, with identical widths.
3. Send 10 bits then a 1000-cycle gap -> o_frame_err pulses once; o_led_data keeps its prior value; o_err_count=1 with the macro, 0 without.
4. Insert 3-cycle glitches high and low mid-bit, plus a 999-cycle low between bits -> glitches ignored, no latch, frame decodes correctly.
5. Assert i_rst_n low after 12 bits -> all outputs 0 immediately; a following full frame latches correctly.
6. Send pulses of exactly 59 and 60 high cycles -> decoded as 0 and 1 respectively.

Source files
------------

// File: rtl/led_chain_node.sv
// One-wire pulse-width LED chain node: captures the first NUM_CHANNELS*BITS_PER_CH bits, forwards the rest.
// Optional frame/error statistics counters enabled by defining LED_FRAME_STATS_EN.
module led_chain_node #(
  parameter int unsigned NUM_CHANNELS    = 1,
  parameter int unsigned BITS_PER_CH     = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 5,
  parameter int unsigned CWIDTH          = 10,
  parameter int unsigned T_THRESH        = 60,
  parameter int unsigned T_LATCH         = 1000
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_serial,
  output logic                                o_serial,
  output logic [NUM_CHANNELS*BITS_PER_CH-1:0] o_led_data,
  output logic                                o_frame_valid,
  output logic                                o_frame_err,
  output logic [15:0]                         o_frame_count,
  output logic [7:0]                          o_err_count
);

  localparam int unsigned NBITS = NUM_CHANNELS * BITS_PER_CH;
  localparam int unsigned BCW   = $clog2(NBITS + 1);
  localparam int unsigned DCW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CWIDTH-1:0] CMAX = '1;

  typedef enum logic [1:0] {IDLE, CAPTURE, FORWARD} state_t;

  state_t            state, state_nxt;
  logic              sync1, sync2, s_in, s_in_d;
  logic [DCW-1:0]    deb_cnt;
  logic [CWIDTH-1:0] high_cnt, low_cnt;
  logic [BCW-1:0]    bit_cnt;
  logic [NBITS-1:0]  cap;
  logic              rise, fall, bit_val, latch_hit, full;
  logic              shift_en, latch_en, serial_nxt, valid_nxt, err_nxt;

  // Synchronizer and debounce: s_in follows sync2 only after a sustained disagreement.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      s_in    <= 1'b0;
      s_in_d  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1  <= i_serial;
      sync2  <= sync1;
      s_in_d <= s_in;
      if (sync2 == s_in) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DCW'(DEBOUNCE_CYCLES - 1)) begin
        s_in    <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DCW'(1);
      end
    end
  end

  assign rise      = s_in & ~s_in_d;
  assign fall      = ~s_in & s_in_d;
  assign bit_val   = (high_cnt >= CWIDTH'(T_THRESH));
  assign latch_hit = (low_cnt == CWIDTH'(T_LATCH));
  assign full      = (bit_cnt == BCW'(NBITS));

  // High counter holds the width of the current/last high phase; low counter the current gap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (rise) high_cnt <= CWIDTH'(1);
      else if (s_in && high_cnt != CMAX) high_cnt <= high_cnt + CWIDTH'(1);
      if (s_in) low_cnt <= '0;
      else if (low_cnt != CMAX) low_cnt <= low_cnt + CWIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rise) state_nxt = CAPTURE;
      CAPTURE: begin
        if (latch_hit) state_nxt = IDLE;
        else if (fall && bit_cnt == BCW'(NBITS - 1)) state_nxt = FORWARD;
      end
      FORWARD: if (latch_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en   = 1'b0;
    latch_en   = 1'b0;
    serial_nxt = 1'b0;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    unique case (state)
      CAPTURE: begin
        shift_en = fall;
        latch_en = latch_hit;
      end
      FORWARD: begin
        serial_nxt = s_in;
        latch_en   = latch_hit;
      end
      default: ;
    endcase
    valid_nxt = latch_en && full;
    err_nxt   = latch_en && !full && (bit_cnt != '0);
  end

  // Capture register publishes to o_led_data only on a complete frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_serial      <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frame_err   <= 1'b0;
      o_led_data    <= '0;
      bit_cnt       <= '0;
      cap           <= '0;
    end else begin
      o_serial      <= serial_nxt;
      o_frame_valid <= valid_nxt;
      o_frame_err   <= err_nxt;
      if (valid_nxt) o_led_data <= cap;
      if (latch_en) begin
        bit_cnt <= '0;
        cap     <= '0;
      end else if (shift_en) begin
        cap     <= {cap[NBITS-2:0], bit_val};
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

`ifdef LED_FRAME_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_count <= '0;
      o_err_count   <= '0;
    end else begin
      if (o_frame_valid) o_frame_count <= o_frame_count + 16'd1;
      if (o_frame_err && o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
    end
  end
`else
  assign o_frame_count = '0;
  assign o_err_count   = '0;
`endif

endmodule

// File: tb/tb_led_chain_node.sv
// Directed bench for led_chain_node: a 1x24 node and a 2x32 node driven by hand-built pulse streams.
module tb_led_chain_node;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser1 = 1'b0, ser2 = 1'b0;
  logic        s1, v1, e1, s2, v2, e2;
  logic [23:0] led1;
  logic [63:0] led2;
  logic [15:0] fc1, fc2;
  logic [7:0]  ec1, ec2;

  int ntests = 0, nfail = 0;
  int cyc = 0;
  int nv1 = 0, ne1 = 0, ns1 = 0, nv2 = 0, both = 0;
  int fc1_m = 0, ec1_m = 0;
  int in_rise[$];
  int out_rise[$];
  int out_width[$];
  int rise_at = 0;
  logic s2_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_chain_node dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser1), .o_serial(s1), .o_led_data(led1),
    .o_frame_valid(v1), .o_frame_err(e1), .o_frame_count(fc1), .o_err_count(ec1)
  );

  led_chain_node #(.NUM_CHANNELS(2), .BITS_PER_CH(32)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_serial(ser2), .o_serial(s2), .o_led_data(led2),
    .o_frame_valid(v2), .o_frame_err(e2), .o_frame_count(fc2), .o_err_count(ec2)
  );

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (v1) nv1 <= nv1 + 1;
    if (e1) ne1 <= ne1 + 1;
    if (s1) ns1 <= ns1 + 1;
    if (v2) nv2 <= nv2 + 1;
    if ((v1 && e1) || (v2 && e2)) both <= both + 1;
    if (s2 && !s2_prev) rise_at = cyc;
    if (!s2 && s2_prev) begin
      out_rise.push_back(rise_at);
      out_width.push_back(cyc - rise_at);
    end
    s2_prev <= s2;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int exp_stat(input int m);
`ifdef LED_FRAME_STATS_EN
    return m;
`else
    return 0 * m;
`endif
  endfunction

  task automatic set_ser(input int which, input logic v);
    if (which == 1) ser1 = v;
    else            ser2 = v;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bit: high phase then low phase; optional 3-cycle glitches inside each phase.
  task automatic send_bit(input int which, input logic b, input int hi1, input int hi0,
                          input int lo, input logic glitch);
    int hi;
    hi = b ? hi1 : hi0;
    set_ser(which, 1'b1);
    if (which == 2) in_rise.push_back(cyc);
    if (glitch) begin
      wait_cyc(hi / 2);
      set_ser(which, 1'b0);
      wait_cyc(3);
      set_ser(which, 1'b1);
      wait_cyc(hi - hi / 2 - 3);
      set_ser(which, 1'b0);
      wait_cyc(20);
      set_ser(which, 1'b1);
      wait_cyc(3);
      set_ser(which, 1'b0);
      wait_cyc(lo - 23);
    end else begin
      wait_cyc(hi);
      set_ser(which, 1'b0);
      wait_cyc(lo);
    end
  endtask

  task automatic send_frame(input int which, input logic [71:0] d, input int n,
                            input int hi1, input int hi0);
    for (int i = 0; i < n; i++) send_bit(which, d[71-i], hi1, hi0, 50, 1'b0);
    wait_cyc(1100);
  endtask

  typedef struct {
    logic [23:0] data;
    int          nbits;
    int          hi1;
    int          hi0;
    logic [23:0] exp_led;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int pv, pe;
    logic [71:0] d;
    logic [7:0]  tail;

    tbl[0] = '{24'hA5C3F0, 24,   80, 30, 24'hA5C3F0, 1, 0};
    tbl[1] = '{24'h123456, 24,   60, 59, 24'h123456, 1, 0};
    tbl[2] = '{24'hFFC000, 10,   80, 30, 24'h123456, 0, 1};
    tbl[3] = '{24'h000001, 24, 1100, 30, 24'h000001, 1, 0};
    tbl[4] = '{24'h5A5A5A, 24,   80, 59, 24'h5A5A5A, 1, 0};

    wait_cyc(3);
    check("rst_led1", 64'(led1), 64'h0);
    check("rst_serial1", 64'(s1), 64'h0);
    check("rst_valid1", 64'(v1), 64'h0);
    check("rst_err1", 64'(e1), 64'h0);
    check("rst_led2", led2, 64'h0);
    rst_n = 1'b1;
    wait_cyc(5);

    for (int t = 0; t < 5; t++) begin
      pv = nv1;
      pe = ne1;
      send_frame(1, {tbl[t].data, 48'h0}, tbl[t].nbits, tbl[t].hi1, tbl[t].hi0);
      fc1_m += tbl[t].exp_valid;
      ec1_m += tbl[t].exp_err;
      check($sformatf("vec%0d_led", t), 64'(led1), 64'(tbl[t].exp_led));
      check($sformatf("vec%0d_valid", t), 64'(nv1 - pv), 64'(tbl[t].exp_valid));
      check($sformatf("vec%0d_err", t), 64'(ne1 - pe), 64'(tbl[t].exp_err));
      check($sformatf("vec%0d_fcount", t), 64'(fc1), 64'(exp_stat(fc1_m)));
      check($sformatf("vec%0d_ecount", t), 64'(ec1), 64'(exp_stat(ec1_m)));
    end

    // 2x32 node: 64 captured bits, 8 forwarded.
    tail = 8'b1011_0010;
    d = {64'hDEADBEEF_01234567, tail};
    pv = nv2;
    send_frame(2, d, 72, 80, 30);
    check("fwd_led2", led2, 64'hDEADBEEF_01234567);
    check("fwd_valid2", 64'(nv2 - pv), 64'd1);
    check("fwd_fcount2", 64'(fc2), 64'(exp_stat(1)));
    check("fwd_pulses", 64'(out_rise.size()), 64'd8);
    for (int k = 0; k < 8 && k < out_rise.size(); k++) begin
      check($sformatf("fwd%0d_latency", k), 64'(out_rise[k] - in_rise[64+k]), 64'd8);
      check($sformatf("fwd%0d_width", k), 64'(out_width[k]), tail[7-k] ? 64'd80 : 64'd30);
    end

    // Glitches inside bits and a 999-cycle gap must not disturb the frame.
    d = {24'h5A0F3C, 48'h0};
    pv = nv1;
    pe = ne1;
    for (int i = 0; i < 24; i++)
      send_bit(1, d[71-i], 80, 30, (i == 11) ? 999 : 50, (i == 2 || i == 7));
    wait_cyc(1100);
    fc1_m++;
    check("glitch_led", 64'(led1), 64'h5A0F3C);
    check("glitch_valid", 64'(nv1 - pv), 64'd1);
    check("glitch_err", 64'(ne1 - pe), 64'd0);

    // Reset mid-frame clears everything immediately.
    for (int i = 0; i < 12; i++) send_bit(1, 1'b1, 80, 30, 50, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_led1", 64'(led1), 64'h0);
    check("midrst_serial1", 64'(s1), 64'h0);
    check("midrst_fcount1", 64'(fc1), 64'h0);
    check("midrst_ecount1", 64'(ec1), 64'h0);
    check("midrst_led2", led2, 64'h0);
    fc1_m = 0;
    ec1_m = 0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(5);
    pv = nv1;
    send_frame(1, {24'hC0FFEE, 48'h0}, 24, 80, 30);
    fc1_m++;
    check("postrst_led", 64'(led1), 64'hC0FFEE);
    check("postrst_valid", 64'(nv1 - pv), 64'd1);
    check("postrst_fcount", 64'(fc1), 64'(exp_stat(fc1_m)));

    check("serial1_never_high", 64'(ns1), 64'd0);
    check("valid_err_exclusive", 64'(both), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
